// File: rtl/seq_signed_div.sv
// Sequential signed divider: 2*DW-bit dividend / DW-bit divisor, radix-2 restoring on magnitudes,
// saturated DW-bit quotient. Define SEQ_DIV_ROUND_EN for round-to-nearest (ties away from zero).
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// CALC  | one quotient bit per cycle, 2*DW cycles, MSB first
// SIGN  | apply rounding, sign and saturation; load result registers
// DONE  | done pulse; results held
module seq_signed_div #(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2*DW-1:0]   dividend,
    input  logic [DW-1:0]     divisor,
    output logic              busy,
    output logic              done,
    output logic [DW-1:0]     quotient,
    output logic [DW-1:0]     remainder,
    output logic              overflow,
    output logic              div_by_zero
);

    localparam int CW = $clog2(2 * DW);

    localparam logic [DW-1:0]   Q_MAX      = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   Q_MIN      = {1'b1, {(DW-1){1'b0}}};
    localparam logic [2*DW:0]   QM_POS_LIM = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [2*DW:0]   QM_NEG_LIM = {{(DW+1){1'b0}}, 1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*DW-1:0]   dvd_q, dvd_d;
    logic [DW-1:0]     dvs_q, dvs_d;
    logic [DW:0]       pr_q, pr_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dz_q, dz_d;
    logic [DW-1:0]     dz_rem_q, dz_rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DW-1:0]     quotient_q, quotient_d;
    logic [DW-1:0]     remainder_q, remainder_d;
    logic              overflow_q, overflow_d;
    logic              dbz_q, dbz_d;

    logic [DW+1:0]     pr_shift;
    logic              trial_ge;
    logic [DW-1:0]     rm;
    logic [2*DW:0]     qm_fin;
    logic              qm_ovf;
    logic [DW-1:0]     q_mag;

    // The dividend register doubles as the quotient: dividend bits leave at the MSB
    // while quotient bits enter at the LSB.
    assign pr_shift = {pr_q, dvd_q[2*DW-1]};
    assign trial_ge = pr_shift >= {2'b00, dvs_q};
    assign rm       = pr_q[DW-1:0];

`ifdef SEQ_DIV_ROUND_EN
    logic round_up;
    assign round_up = {rm, 1'b0} >= {1'b0, dvs_q};
    assign qm_fin   = {1'b0, dvd_q} + {{(2*DW){1'b0}}, round_up};
`else
    assign qm_fin   = {1'b0, dvd_q};
`endif

    assign qm_ovf = neg_quo_q ? (qm_fin > QM_NEG_LIM) : (qm_fin > QM_POS_LIM);
    assign q_mag  = qm_fin[DW-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        pr_d        = pr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;
        dz_rem_d    = dz_rem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        overflow_d  = overflow_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CALC;
                    busy_d     = 1'b1;
                    overflow_d = 1'b0;
                    dbz_d      = 1'b0;
                    neg_quo_d  = dividend[2*DW-1] ^ divisor[DW-1];
                    neg_rem_d  = dividend[2*DW-1];
                    dvd_d      = dividend[2*DW-1] ? -dividend : dividend;
                    dvs_d      = divisor[DW-1] ? -divisor : divisor;
                    dz_d       = (divisor == '0);
                    dz_rem_d   = dividend[DW-1:0];
                    pr_d       = '0;
                    cnt_d      = CW'(2 * DW - 1);
                end
            end
            S_CALC: begin
                dvd_d = {dvd_q[2*DW-2:0], trial_ge};
                pr_d  = trial_ge ? (DW+1)'(pr_shift - {2'b00, dvs_q}) : pr_shift[DW:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (dz_q) begin
                    quotient_d  = neg_rem_q ? Q_MIN : Q_MAX;
                    remainder_d = dz_rem_q;
                    overflow_d  = 1'b0;
                    dbz_d       = 1'b1;
                end else begin
                    overflow_d  = qm_ovf;
                    dbz_d       = 1'b0;
                    if (qm_ovf) begin
                        quotient_d = neg_quo_q ? Q_MIN : Q_MAX;
                    end else begin
                        quotient_d = neg_quo_q ? -q_mag : q_mag;
                    end
                    remainder_d = neg_rem_q ? -rm : rm;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            pr_q        <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            dz_rem_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            pr_q        <= pr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dz_q        <= dz_d;
            dz_rem_q    <= dz_rem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            overflow_q  <= overflow_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_signed_div.sv
// Self-checking bench for seq_signed_div (DW=16): directed cases plus random operands
// compared against an arithmetic reference model; honours SEQ_DIV_ROUND_EN.
module tb_seq_signed_div;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   dividend = '0;
    logic [15:0]   divisor = '0;
    logic          busy;
    logic          done;
    logic [15:0]   quotient;
    logic [15:0]   remainder;
    logic          overflow;
    logic          div_by_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_signed_div #(.DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating integer division on magnitudes, then rounding, sign, saturation.
    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  output logic [15:0] eq, output logic [15:0] er,
                                  output logic eo, output logic ez);
        longint sa, sb, ma, mb, qm, rm, sq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eo = 1'b0;
        ez = 1'b0;
        if (sb == 0) begin
            ez = 1'b1;
            eq = (sa < 0) ? 16'h8000 : 16'h7FFF;
            er = a[15:0];
            return;
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        qm = ma / mb;
        rm = ma % mb;
`ifdef SEQ_DIV_ROUND_EN
        if (2 * rm >= mb) qm = qm + 1;
`endif
        sq = ((sa < 0) != (sb < 0)) ? -qm : qm;
        if (sq > 32767) begin
            eq = 16'h7FFF;
            eo = 1'b1;
        end else if (sq < -32768) begin
            eq = 16'h8000;
            eo = 1'b1;
        end else begin
            eq = sq[15:0];
        end
        er = (sa < 0) ? 16'(-rm) : 16'(rm);
    endfunction

    task automatic run_div(input logic [31:0] a, input logic [15:0] b, input int poke,
                           input string tag);
        logic [15:0] eq, er;
        logic        eo, ez, busy_ok;
        int          cyc, extra;
        model(a, b, eq, er, eo, ez);
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(negedge clk);
        start = 1'b0;
        dividend = $urandom;
        divisor = 16'($urandom);
        cyc = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = (cyc == poke);
            if (cyc == poke) begin
                dividend = ~a;
                divisor = b ^ 16'h0005;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(2 * DW + 2));
        check({tag, " busy_in_flight"}, 64'(busy_ok), 64'(1));
        check({tag, " busy_at_done"}, 64'(busy), 64'(0));
        check({tag, " quotient"}, 64'(quotient), 64'(eq));
        check({tag, " remainder"}, 64'(remainder), 64'(er));
        check({tag, " overflow"}, 64'(overflow), 64'(eo));
        check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 64'(done), 64'(0));
        if (poke > 0) begin
            extra = 0;
            repeat (40) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            check({tag, " extra_done"}, 64'(extra), 64'(0));
            check({tag, " quotient_held"}, 64'(quotient), 64'(eq));
        end
    endtask

    initial begin
        logic [15:0] eq, er;
        logic        eo, ez;
        int          cyc, ndone, first_done, second_done;
        logic [31:0] ra;
        logic [15:0] rb;
        logic [19:0] t20;

        // Power-on reset
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst quotient", 64'(quotient), 64'(0));
        check("rst remainder", 64'(remainder), 64'(0));
        check("rst overflow", 64'(overflow), 64'(0));
        check("rst div_by_zero", 64'(div_by_zero), 64'(0));
        rst_n = 1'b1;

        run_div(32'd100, 16'd7, 0, "p100_d7");
        check("p100_d7 const_q", 64'(quotient), 64'(14));
        check("p100_d7 const_r", 64'(remainder), 64'(2));
        run_div(32'hFFFF_FF9C, 16'd7, 0, "m100_d7");
        check("m100_d7 const_q", 64'(quotient), 64'h0000_FFF2);
        check("m100_d7 const_r", 64'(remainder), 64'h0000_FFFE);
        run_div(32'd100, 16'hFFF9, 0, "p100_m7");
        run_div(32'h4000_0000, 16'd2, 0, "ovf_pos");
        check("ovf_pos const_q", 64'(quotient), 64'h7FFF);
        run_div(32'hC000_0000, 16'd2, 0, "ovf_neg");
        check("ovf_neg const_q", 64'(quotient), 64'h8000);
        run_div(32'hFFFF_FFFB, 16'd0, 0, "dz_m5");
        check("dz_m5 const_q", 64'(quotient), 64'h8000);
        check("dz_m5 const_r", 64'(remainder), 64'hFFFB);
        run_div(32'd100, 16'd8, 0, "p100_d8");
`ifdef SEQ_DIV_ROUND_EN
        check("p100_d8 const_q", 64'(quotient), 64'(13));
`else
        check("p100_d8 const_q", 64'(quotient), 64'(12));
`endif
        check("p100_d8 const_r", 64'(remainder), 64'(4));
        run_div(32'h8000_0000, 16'hFFFF, 0, "min_by_m1");
        run_div(32'h8000_0000, 16'd1, 0, "min_by_1");
        run_div(32'hFFFF_8000, 16'd1, 0, "qmin_edge");
        run_div(32'h0000_8000, 16'hFFFF, 0, "qmin_neg_edge");
        run_div(32'h0000_8000, 16'd1, 0, "qmax_plus1");
        run_div(32'h7FFF_FFFF, 16'h8000, 0, "max_by_min");
        run_div(32'd7, 16'd0, 0, "dz_p7");
        run_div(32'd1234567, 16'd300, 5, "ignored_start");

        // Reset while a division is in flight
        @(negedge clk);
        start = 1'b1;
        dividend = 32'd1000;
        divisor = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'(0));
        check("midrst done", 64'(done), 64'(0));
        check("midrst quotient", 64'(quotient), 64'(0));
        check("midrst remainder", 64'(remainder), 64'(0));
        check("midrst overflow", 64'(overflow), 64'(0));
        check("midrst div_by_zero", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (50) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("midrst no_done", 64'(ndone), 64'(0));
        check("midrst idle", 64'(busy), 64'(0));

        // start held high: back-to-back divisions with 2*DW+3 spacing
        model(32'hFFFF_F000, 16'd9, eq, er, eo, ez);
        @(negedge clk);
        start = 1'b1;
        dividend = 32'hFFFF_F000;
        divisor = 16'd9;
        @(negedge clk);
        cyc = 1;
        ndone = 0;
        first_done = -1;
        second_done = -1;
        while (ndone < 2 && cyc < 100) begin
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) first_done = cyc;
                else second_done = cyc;
            end
            if (ndone < 2) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check("held first_done", 64'(first_done), 64'(2 * DW + 2));
        check("held second_done", 64'(second_done), 64'(2 * (2 * DW + 2) + 1));
        check("held quotient", 64'(quotient), 64'(eq));
        check("held remainder", 64'(remainder), 64'(er));
        repeat (3) @(negedge clk);
        check("held no_third", 64'(busy), 64'(0));

        // Random operands
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: ra = $urandom;
                1: begin
                    t20 = 20'($urandom);
                    ra = {{12{t20[19]}}, t20};
                end
                2: ra = {{16{1'b0}}, 16'($urandom)};
                default: begin
                    t20 = 20'($urandom);
                    ra = {{12{1'b1}}, t20};
                end
            endcase
            case ($urandom_range(0, 5))
                0: rb = 16'd0;
                1: rb = 16'($urandom_range(1, 20));
                2: rb = -16'($urandom_range(1, 20));
                3: rb = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
                default: rb = 16'($urandom);
            endcase
            run_div(ra, rb, 0, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
